// File: rtl/stopwatch_pkg.sv
// Shared stopwatch constants and types: per-field moduli/widths and the packed BCD digit pair.
// Imported by the modulo-N counter, its bus interface and the optional BCD converter.
package stopwatch_pkg;

    localparam int SEC_MODULUS  = 60;
    localparam int MIN_MODULUS  = 60;
    localparam int HOUR_MODULUS = 24;

    localparam int SEC_WIDTH  = 6;
    localparam int MIN_WIDTH  = 6;
    localparam int HOUR_WIDTH = 5;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_pair_t;

endpackage

// File: rtl/mod_n_counter_if.sv
// Control/status bundle for one counter field; master drives controls, slave is the counter.
// With MOD_N_COUNTER_BCD_EN defined the bundle also carries the registered BCD view of count.
interface mod_n_counter_if #(
    parameter int WIDTH = 6
);
    import stopwatch_pkg::*;

    logic             enable;
    logic             up_dn;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             at_zero;
    logic             at_max;
    logic             carry_out;

`ifdef MOD_N_COUNTER_BCD_EN
    bcd_pair_t        count_bcd;

    modport master (
        output enable, up_dn, clear, load, load_value,
        input  count, wrap, at_zero, at_max, carry_out, count_bcd
    );

    modport slave (
        input  enable, up_dn, clear, load, load_value,
        output count, wrap, at_zero, at_max, carry_out, count_bcd
    );
`else
    modport master (
        output enable, up_dn, clear, load, load_value,
        input  count, wrap, at_zero, at_max, carry_out
    );

    modport slave (
        input  enable, up_dn, clear, load, load_value,
        output count, wrap, at_zero, at_max, carry_out
    );
`endif

endinterface

// File: rtl/mod_n_counter_bin_to_bcd8.sv
// Combinational binary (0..99) to two-digit BCD converter used for the counter's display view.
// Only compiled when MOD_N_COUNTER_BCD_EN is defined, matching its sole instantiation site.
`ifdef MOD_N_COUNTER_BCD_EN
module bin_to_bcd8
    import stopwatch_pkg::*;
(
    input  logic [6:0] i_value,
    output bcd_pair_t  o_bcd
);

    always_comb begin
        o_bcd.tens  = 4'(i_value / 7'd10);
        o_bcd.units = 4'(i_value % 7'd10);
    end

endmodule
`endif

// File: rtl/mod_n_counter.sv
// Parametrised modulo-N up/down counter with clear, saturating load and lookahead carry.
// Optional registered BCD output is enabled with the MOD_N_COUNTER_BCD_EN macro.
module mod_n_counter
    import stopwatch_pkg::*;
#(
    parameter int MODULUS = 60,
    parameter int WIDTH   = 6
)(
    input  logic           clk,
    input  logic           rst_n,
    mod_n_counter_if.slave bus
);

    generate
        if (MODULUS < 2 || MODULUS > 256) begin : g_badModulus
            $error("mod_n_counter: MODULUS must lie in 2..256");
        end
        if ((64'd1 << WIDTH) < 64'(MODULUS)) begin : g_badWidth
            $error("mod_n_counter: WIDTH too narrow for MODULUS");
        end
`ifdef MOD_N_COUNTER_BCD_EN
        if (MODULUS > 100) begin : g_badBcd
            $error("mod_n_counter: BCD output needs MODULUS <= 100");
        end
`endif
    endgenerate

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH-1:0] w_nextCount;
    logic             w_nextWrap;
    logic             w_atZero;
    logic             w_atMax;

    assign w_atZero = (r_count == '0);
    assign w_atMax  = (r_count == MAX_COUNT);

    // Clear beats load beats step; an out-of-range load saturates at the top value.
    always_comb begin
        w_nextCount = r_count;
        w_nextWrap  = 1'b0;
        if (bus.clear) begin
            w_nextCount = '0;
        end else if (bus.load) begin
            w_nextCount = ({1'b0, bus.load_value} < MOD_EXT) ? bus.load_value : MAX_COUNT;
        end else if (bus.enable) begin
            if (bus.up_dn) begin
                if (w_atMax) begin
                    w_nextCount = '0;
                    w_nextWrap  = 1'b1;
                end else begin
                    w_nextCount = r_count + WIDTH'(1);
                end
            end else begin
                if (w_atZero) begin
                    w_nextCount = MAX_COUNT;
                    w_nextWrap  = 1'b1;
                end else begin
                    w_nextCount = r_count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_nextCount;
            r_wrap  <= w_nextWrap;
        end
    end

    // Carry is combinational so a chain of fields all step on the same edge.
    assign bus.count     = r_count;
    assign bus.wrap      = r_wrap;
    assign bus.at_zero   = w_atZero;
    assign bus.at_max    = w_atMax;
    assign bus.carry_out = bus.enable & (bus.up_dn ? w_atMax : w_atZero);

`ifdef MOD_N_COUNTER_BCD_EN
    logic [6:0] w_bcdIn;
    bcd_pair_t  w_nextBcd;
    bcd_pair_t  r_countBcd;

    assign w_bcdIn = 7'(w_nextCount);

    bin_to_bcd8 u_bcd (
        .i_value (w_bcdIn),
        .o_bcd   (w_nextBcd)
    );

    // Converting the next value keeps the BCD register in step with count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_countBcd <= '0;
        end else begin
            r_countBcd <= w_nextBcd;
        end
    end

    assign bus.count_bcd = r_countBcd;
`endif

endmodule

// File: tb/tb_mod_n_counter.sv
// Bench for mod_n_counter: a seconds (60) field cascaded into an hours (24) field.
// Checks both fields every cycle against a modular-arithmetic model, plus literal expectations.
module tb_mod_n_counter;
    import stopwatch_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    bit en, ud, clr, ld, hClr, hLd;
    int lv, hLv;

    bit checkEn = 1'b0;
    int checks  = 0;
    int errors  = 0;

    int mSec  = 0;
    int mHour = 0;
    bit mSecWrap  = 1'b0;
    bit mHourWrap = 1'b0;

    int nSec, nHour;
    bit wSec, wHour, mCarry;
    bit expCarry, expHourCarry;

    mod_n_counter_if #(.WIDTH(SEC_WIDTH))  secIf ();
    mod_n_counter_if #(.WIDTH(HOUR_WIDTH)) hourIf ();

    assign secIf.enable     = en;
    assign secIf.up_dn      = ud;
    assign secIf.clear      = clr;
    assign secIf.load       = ld;
    assign secIf.load_value = SEC_WIDTH'(lv);

    assign hourIf.enable     = secIf.carry_out;
    assign hourIf.up_dn      = ud;
    assign hourIf.clear      = hClr;
    assign hourIf.load       = hLd;
    assign hourIf.load_value = HOUR_WIDTH'(hLv);

    mod_n_counter #(.MODULUS(SEC_MODULUS), .WIDTH(SEC_WIDTH)) u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (secIf.slave)
    );

    mod_n_counter #(.MODULUS(HOUR_MODULUS), .WIDTH(HOUR_WIDTH)) u_hour (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hourIf.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Next value of a modulo counter from the prose rules: clear, then load, then step.
    function automatic void stepModel(input int cur, input int modulus, input bit c, input bit l,
                                      input int v, input bit e, input bit u,
                                      output int nxt, output bit wr);
        nxt = cur;
        wr  = 1'b0;
        if (c) begin
            nxt = 0;
        end else if (l) begin
            nxt = (v < modulus) ? v : modulus - 1;
        end else if (e) begin
            if (u) begin
                nxt = (cur + 1) % modulus;
                wr  = (cur == modulus - 1);
            end else begin
                nxt = (cur + modulus - 1) % modulus;
                wr  = (cur == 0);
            end
        end
    endfunction

    // Reference model advances from the bench's own inputs and state only.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mSec      = 0;
            mHour     = 0;
            mSecWrap  = 1'b0;
            mHourWrap = 1'b0;
        end else begin
            mCarry = en && (ud ? (mSec == SEC_MODULUS - 1) : (mSec == 0));
            stepModel(mSec, SEC_MODULUS, clr, ld, lv, en, ud, nSec, wSec);
            stepModel(mHour, HOUR_MODULUS, hClr, hLd, hLv, mCarry, ud, nHour, wHour);
            mSec      = nSec;
            mSecWrap  = wSec;
            mHour     = nHour;
            mHourWrap = wHour;
        end
    end

    // Compare process: registered and combinational outputs of both fields every cycle.
    always @(negedge clk) begin
        if (checkEn) begin
            #1;
            expCarry     = en && (ud ? (mSec == SEC_MODULUS - 1) : (mSec == 0));
            expHourCarry = expCarry && (ud ? (mHour == HOUR_MODULUS - 1) : (mHour == 0));
            checkOutput("sec count",      secIf.count,     mSec);
            checkOutput("sec wrap",       secIf.wrap,      mSecWrap);
            checkOutput("sec at_zero",    secIf.at_zero,   mSec == 0);
            checkOutput("sec at_max",     secIf.at_max,    mSec == SEC_MODULUS - 1);
            checkOutput("sec carry_out",  secIf.carry_out, expCarry);
            checkOutput("hour count",     hourIf.count,    mHour);
            checkOutput("hour wrap",      hourIf.wrap,     mHourWrap);
            checkOutput("hour at_zero",   hourIf.at_zero,  mHour == 0);
            checkOutput("hour at_max",    hourIf.at_max,   mHour == HOUR_MODULUS - 1);
            checkOutput("hour carry_out", hourIf.carry_out, expHourCarry);
`ifdef MOD_N_COUNTER_BCD_EN
            checkOutput("sec count_bcd",  secIf.count_bcd,  ((mSec / 10) << 4) | (mSec % 10));
            checkOutput("hour count_bcd", hourIf.count_bcd, ((mHour / 10) << 4) | (mHour % 10));
`endif
        end
    end

    // Drives one cycle of inputs at the falling edge and returns just after the next rising edge.
    task automatic applyStimulus(input bit c, input bit l, input int v, input bit e, input bit u,
                                 input bit hc, input bit hl, input int hv);
        @(negedge clk);
        clr  = c;
        ld   = l;
        lv   = v;
        en   = e;
        ud   = u;
        hClr = hc;
        hLd  = hl;
        hLv  = hv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        en = 0; ud = 1; clr = 0; ld = 0; lv = 0; hClr = 0; hLd = 0; hLv = 0;
        #1 rst_n = 1'b0;
        #1 checkEn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset count",   secIf.count,   0);
        checkOutput("reset wrap",    secIf.wrap,    0);
        checkOutput("reset at_zero", secIf.at_zero, 1);
        checkOutput("reset at_max",  secIf.at_max,  0);
        @(negedge clk);
        rst_n = 1'b1;

        // Counting down from reset wraps both fields immediately.
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("down first count", secIf.count,  59);
        checkOutput("down first wrap",  secIf.wrap,   1);
        checkOutput("down hour borrow", hourIf.count, 23);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("down second count", secIf.count, 58);
        checkOutput("down second wrap",  secIf.wrap,  0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("down third count", secIf.count, 57);

        applyStimulus(1, 0, 0, 0, 1, 1, 0, 0);
        checkOutput("clear count", secIf.count, 0);

        for (int i = 0; i < 60; i++) begin
            applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
            checkOutput("up sweep count", secIf.count, (i + 1) % 60);
            checkOutput("up sweep wrap",  secIf.wrap,  (i == 59) ? 1 : 0);
        end
        checkOutput("up sweep hour carry", hourIf.count, 1);

        applyStimulus(0, 1, 45, 0, 1, 0, 0, 0);
        checkOutput("load 45", secIf.count, 45);
        applyStimulus(0, 1, 63, 0, 1, 0, 0, 0);
        checkOutput("load 63 saturates", secIf.count, 59);
        applyStimulus(0, 1, 10, 1, 1, 0, 0, 0);
        checkOutput("load beats enable", secIf.count, 10);
        applyStimulus(1, 1, 33, 1, 1, 0, 0, 0);
        checkOutput("clear beats load", secIf.count, 0);

        applyStimulus(0, 1, 59, 0, 1, 0, 1, 5);
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
        checkOutput("cascade sec count", secIf.count,  0);
        checkOutput("cascade sec wrap",  secIf.wrap,   1);
        checkOutput("cascade hour step", hourIf.count, 6);
        checkOutput("cascade hour wrap", hourIf.wrap,  0);
        applyStimulus(0, 1, 59, 0, 1, 0, 1, 23);
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
        checkOutput("double wrap sec",       secIf.count,  0);
        checkOutput("double wrap hour",      hourIf.count, 0);
        checkOutput("double wrap hour wrap", hourIf.wrap,  1);

        // Asynchronous reset in the middle of a cycle.
        applyStimulus(0, 1, 37, 0, 1, 0, 0, 0);
        checkOutput("preload 37", secIf.count, 37);
        #2;
        rst_n = 1'b0;
        en = 0; ld = 0; clr = 0; hLd = 0; hClr = 0;
        #1;
        checkOutput("async reset count",      secIf.count,  0);
        checkOutput("async reset wrap",       secIf.wrap,   0);
        checkOutput("async reset hour count", hourIf.count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
        checkOutput("resume after reset", secIf.count, 1);

`ifdef MOD_N_COUNTER_BCD_EN
        applyStimulus(1, 0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 42; i++) applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
        checkOutput("bcd 42", secIf.count_bcd, 32'h42);
        for (int i = 42; i < 59; i++) applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
        checkOutput("bcd 59", secIf.count_bcd, 32'h59);
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
        checkOutput("bcd wrap 00", secIf.count_bcd, 32'h00);
`endif

        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(99) < 3, $urandom_range(99) < 5, $urandom_range(63),
                          $urandom_range(99) < 75, $urandom_range(99) < 60,
                          $urandom_range(99) < 2, $urandom_range(99) < 3, $urandom_range(31));
        end

        @(negedge clk);
        #3;
        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_n_counter.md
# mod_n_counter

Parametrised modulo-N counter, the general successor of the stopwatch seconds counter. It adds a configurable modulus and width, up/down counting, synchronous clear and load, and a lookahead carry for ripple-free cascading. One instance per time field (seconds, minutes, hours) in the stopwatch datapath; higher fields are chained through `carry_out` into the next field's `enable`.

## Interface
- `MODULUS`, default 60: count range is 0..MODULUS-1; legal range 2..256.
- `WIDTH`, default 6: width of `count` and `load_value`. Must satisfy 2^WIDTH >= MODULUS. Elaboration fails otherwise.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: advance one step this cycle.
- `up_dn` input 1: 1 = count up, 0 = count down; sampled only when `enable`=1.
- `clear` input 1: synchronous clear to 0.
- `load` input 1: synchronous load of `load_value`.
- `load_value` input WIDTH: value to load.
- `count` output WIDTH: registered count.
- `wrap` output 1: registered one-cycle pulse on wrap-around.
- `at_zero` output 1: combinational, `count`==0.
- `at_max` output 1: combinational, `count`==MODULUS-1.
- `carry_out` output 1: combinational, `enable` & (`up_dn` ? `at_max` : `at_zero`).
- `count_bcd` output 8: present only with MOD_N_COUNTER_BCD_EN.

## Operation
- Priority per edge, highest first: `clear`, then `load`, then `enable`, then hold.
- `clear`: `count`<=0, `wrap`<=0. This holds regardless of `enable`, `load` or `up_dn`.
- `load`: `count`<=`load_value` if `load_value` < MODULUS, else `count`<=MODULUS-1 (saturating). `wrap`<=0.
- `enable` with `up_dn`=1:
  - At MODULUS-1: `count`<=0, `wrap`<=1.
  - Otherwise: `count`<=`count`+1, `wrap`<=0.
- `enable` with `up_dn`=0:
  - At 0: `count`<=MODULUS-1, `wrap`<=1.
  - Otherwise: `count`<=`count`-1, `wrap`<=0.
- Hold (no `clear`, `load` or `enable`): `count` unchanged, `wrap`<=0.
- `wrap` is therefore high for exactly one cycle per wrap. It coincides with `count` showing the wrapped value (0 going up, MODULUS-1 going down).
- Arithmetic is done in WIDTH bits. `count` never leaves 0..MODULUS-1 under any input sequence.
- Cascading: the next field's `enable` is this field's `carry_out`. All fields then step on the same edge, with no one-cycle lag per stage.

## Timing
- Reset (asynchronous, `rst_n`=0): `count`=0, `wrap`=0, `count_bcd`=0. Derived outputs follow: `at_zero`=1, `at_max`=0, `carry_out`=`enable` & !`up_dn`.
- Reset release is synchronous-safe. The first update occurs on the first rising edge with `rst_n`=1.
- Reset asserted mid-count: outputs go to reset values immediately, without waiting for a clock edge.
- Latency for `clear`, `load` and `enable`: one cycle, input to `count`/`wrap`.
- `at_zero`, `at_max`, `carry_out`: zero latency (combinational) from `count` and `enable`/`up_dn`.
- A direction change takes effect on the same edge it is sampled with `enable`.
- `load`+`enable` together: the load wins and no step occurs. `clear`+`load` together: the clear wins.

## Configuration
- Macro: MOD_N_COUNTER_BCD_EN.
- Defined:
  - Port `count_bcd` exists: {tens, units} BCD of the next `count`, registered on the same edge, so it always equals BCD(`count`).
  - Requires MODULUS <= 100. Elaboration fails otherwise.
- Undefined:
  - The port and the conversion logic are absent. All other behaviour is identical.

## Structure
- Shared package `stopwatch_pkg` holds:
  - Field moduli constants: SEC_MODULUS=60, MIN_MODULUS=60, HOUR_MODULUS=24.
  - Field width constants: SEC_WIDTH=6, MIN_WIDTH=6, HOUR_WIDTH=5.
  - A BCD pair typedef (8 bits: tens[7:4], units[3:0]).
- One sub-module: `bin_to_bcd8`, combinational 0..99 to the 8-bit BCD pair. It is instantiated only under MOD_N_COUNTER_BCD_EN.

## Test plan
- Reset, then `enable`=1, `up_dn`=1 for 60 cycles (MODULUS=60) -> `count` 0..59 then 0. `wrap`=1 only on the cycle `count` returns to 0. `carry_out`=1 only while `count`=59.
- `up_dn`=0, `enable`=1 from reset -> next `count`=59 with `wrap`=1, then 58, 57.
- `load`=1, `load_value`=45 -> `count`=45. `load_value`=63 -> `count`=59. `load`+`enable` together -> loaded value with no step. `clear`+`load` together -> 0.
- Two instances (60, 24) cascaded via `carry_out`; seconds loaded to 59 with `enable` held -> on one edge seconds=0 and hours field increments. `wrap` pulses in both instances where applicable.
- `rst_n` dropped asynchronously mid-count at `count`=37 -> `count`=0 and `wrap`=0 before the next edge. Counting resumes from 1 after release.
- With MOD_N_COUNTER_BCD_EN, count to 42 -> `count_bcd`=8'h42. Wrap at 59 -> 8'h59 then 8'h00.
